spi_reg_arbiter: RTL and testbench

SPI_REG_ARBITER -- requirements
Module: spi_reg_arbiter

---
 rtl/spi_pkg.sv | 34 +++
 rtl/spi_wr_pend.sv | 35 +++
 rtl/spi_reg_arbiter.sv | 164 ++++++++++++++++
 tb/tb_spi_reg_arbiter.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI/internal register write arbiter.
// Optional feature macro used by this slice: SPI_ARB_WRCOUNT_EN.
package spi_pkg;

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 8;

  localparam logic [AW-1:0] ADDR_REG1 = AW'(1);
  localparam logic [AW-1:0] ADDR_REG2 = AW'(2);
  localparam logic [AW-1:0] ADDR_REG3 = AW'(3);

  // reg3 bit that blocks internal writes when set
  localparam int unsigned LOCK_BIT = 7;

  // SPI write of this value to reg3 also clears the sticky overflow flag
  localparam logic [DW-1:0] OVF_CLR_DATA = DW'(8'hFF);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SPI_COMMIT,
    ST_INT_COMMIT,
    ST_INT_ACK
  } arb_state_e;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_req_t;

  function automatic logic addr_valid(input logic [AW-1:0] a);
    return (a == ADDR_REG1) || (a == ADDR_REG2) || (a == ADDR_REG3);
  endfunction

endpackage

// File: rtl/spi_wr_pend.sv
// One-entry holding register for SPI writes, with lost-strobe detection.
module spi_wr_pend
  import spi_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    wr_valid_i,
  input  wr_req_t wr_i,
  input  logic    clr_i,
  output logic    pend_o,
  output wr_req_t wr_o,
  output logic    drop_c
);

  logic    pend_q;
  wr_req_t wr_q;

  // A strobe is taken when the slot is empty or being freed on this same edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= 1'b0;
      wr_q   <= '0;
    end else if (wr_valid_i && (!pend_q || clr_i)) begin
      pend_q <= 1'b1;
      wr_q   <= wr_i;
    end else if (clr_i) begin
      pend_q <= 1'b0;
    end
  end

  assign drop_c = wr_valid_i & pend_q & ~clr_i;
  assign pend_o = pend_q;
  assign wr_o   = wr_q;

endmodule

// File: rtl/spi_reg_arbiter.sv
// Arbitrates SPI and internal writes into three 8-bit registers.
// Optional write counter output enabled by defining SPI_ARB_WRCOUNT_EN.
module spi_reg_arbiter
  import spi_pkg::*;
#(
  parameter logic [7:0] REG1_RST = 8'h00,
  parameter logic [7:0] REG2_RST = 8'h00,
  parameter logic [7:0] REG3_RST = 8'h00
) (
  input  logic         iclk,
  input  logic         rstn,
  input  logic         spi_wr_valid,
  input  logic [7:0]   spi_addr,
  input  logic [7:0]   spi_wdata,
  input  logic         int_wr_req,
  input  logic [7:0]   int_addr,
  input  logic [7:0]   int_wdata,
  output logic         int_wr_gnt,
  output logic         int_wr_err,
  output logic [7:0]   reg1,
  output logic [7:0]   reg2,
  output logic [7:0]   reg3,
  output logic         spi_ovf,
  output logic         addr_err
`ifdef SPI_ARB_WRCOUNT_EN
  ,
  output logic [7:0]   wr_count
`endif
);

  arb_state_e     state_q;
  logic [DW-1:0]  reg1_q, reg2_q, reg3_q;
  logic           gnt_q, err_q, ovf_q, addr_err_q;

  logic           pend_c;
  wr_req_t        pend_wr_c;
  logic           drop_c;
  logic           pend_clr_c;
  logic           locked_c;
  logic           commit_c;
  logic           wr_en_c;
  logic           wr_ok_c;
  logic           ovf_clr_c;
  logic [AW-1:0]  wr_addr_c;
  logic [DW-1:0]  wr_data_c;

  assign pend_clr_c = (state_q == ST_SPI_COMMIT);
  assign locked_c   = reg3_q[LOCK_BIT];

  spi_wr_pend u_pend (
    .clk        (iclk),
    .rst_n      (rstn),
    .wr_valid_i (spi_wr_valid),
    .wr_i       ('{addr: spi_addr, data: spi_wdata}),
    .clr_i      (pend_clr_c),
    .pend_o     (pend_c),
    .wr_o       (pend_wr_c),
    .drop_c     (drop_c)
  );

  // Select the write source for the current commit state
  always_comb begin
    commit_c  = 1'b0;
    wr_en_c   = 1'b0;
    wr_addr_c = '0;
    wr_data_c = '0;
    case (state_q)
      ST_SPI_COMMIT: begin
        commit_c  = 1'b1;
        wr_en_c   = 1'b1;
        wr_addr_c = pend_wr_c.addr;
        wr_data_c = pend_wr_c.data;
      end
      ST_INT_COMMIT: begin
        commit_c  = 1'b1;
        wr_en_c   = ~locked_c;
        wr_addr_c = int_addr;
        wr_data_c = int_wdata;
      end
      default: ;
    endcase
  end

  assign wr_ok_c   = wr_en_c & addr_valid(wr_addr_c);
  assign ovf_clr_c = pend_clr_c && (pend_wr_c.addr == ADDR_REG3) &&
                     (pend_wr_c.data == OVF_CLR_DATA);

  // Arbitration FSM, register file and status flags
  always_ff @(posedge iclk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      reg1_q     <= REG1_RST;
      reg2_q     <= REG2_RST;
      reg3_q     <= REG3_RST;
      gnt_q      <= 1'b0;
      err_q      <= 1'b0;
      ovf_q      <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      gnt_q      <= 1'b0;
      err_q      <= 1'b0;
      addr_err_q <= commit_c && !addr_valid(wr_addr_c);

      if (wr_ok_c) begin
        case (wr_addr_c)
          ADDR_REG1: reg1_q <= wr_data_c;
          ADDR_REG2: reg2_q <= wr_data_c;
          ADDR_REG3: reg3_q <= wr_data_c;
          default: ;
        endcase
      end

      // a fresh loss wins over a clearing write on the same edge
      if (drop_c) begin
        ovf_q <= 1'b1;
      end else if (ovf_clr_c) begin
        ovf_q <= 1'b0;
      end

      case (state_q)
        ST_IDLE: begin
          // an arriving strobe already counts as pending for priority
          if (pend_c) begin
            state_q <= ST_SPI_COMMIT;
          end else if (int_wr_req && !spi_wr_valid) begin
            state_q <= ST_INT_COMMIT;
          end
        end
        ST_SPI_COMMIT: state_q <= int_wr_req ? ST_INT_COMMIT : ST_IDLE;
        ST_INT_COMMIT: begin
          state_q <= ST_INT_ACK;
          gnt_q   <= 1'b1;
          err_q   <= locked_c;
        end
        ST_INT_ACK:    state_q <= ST_IDLE;
        default:       state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef SPI_ARB_WRCOUNT_EN
  logic [7:0] wcnt_q;

  // Saturating count of register writes that actually landed
  always_ff @(posedge iclk or negedge rstn) begin
    if (!rstn) begin
      wcnt_q <= '0;
    end else if (wr_ok_c && (wcnt_q != 8'hFF)) begin
      wcnt_q <= wcnt_q + 8'd1;
    end
  end

  assign wr_count = wcnt_q;
`endif

  assign reg1       = reg1_q;
  assign reg2       = reg2_q;
  assign reg3       = reg3_q;
  assign int_wr_gnt = gnt_q;
  assign int_wr_err = err_q;
  assign spi_ovf    = ovf_q;
  assign addr_err   = addr_err_q;

endmodule

// File: tb/tb_spi_reg_arbiter.sv
// Self-checking bench for spi_reg_arbiter; honours SPI_ARB_WRCOUNT_EN.
module tb_spi_reg_arbiter;

  localparam logic [7:0] R1 = 8'hA1;
  localparam logic [7:0] R2 = 8'hB2;
  localparam logic [7:0] R3 = 8'h03;

  logic       iclk = 1'b0;
  logic       rstn;
  logic       spi_wr_valid;
  logic [7:0] spi_addr, spi_wdata;
  logic       int_wr_req;
  logic [7:0] int_addr, int_wdata;
  logic       int_wr_gnt, int_wr_err, spi_ovf, addr_err;
  logic [7:0] reg1, reg2, reg3;
`ifdef SPI_ARB_WRCOUNT_EN
  logic [7:0] wr_count;
`endif

  typedef struct packed {
    logic err;
    logic aerr;
  } exp_t;

  exp_t       sb_q[$];
  exp_t       mon_e;
  int         n_tot = 0;
  int         n_bad = 0;
  logic [7:0] m1, m2, m3, m_wc;
  logic       seen;

  always #5 iclk = ~iclk;

  spi_reg_arbiter #(
    .REG1_RST(R1), .REG2_RST(R2), .REG3_RST(R3)
  ) dut (
    .iclk         (iclk),
    .rstn         (rstn),
    .spi_wr_valid (spi_wr_valid),
    .spi_addr     (spi_addr),
    .spi_wdata    (spi_wdata),
    .int_wr_req   (int_wr_req),
    .int_addr     (int_addr),
    .int_wdata    (int_wdata),
    .int_wr_gnt   (int_wr_gnt),
    .int_wr_err   (int_wr_err),
    .reg1         (reg1),
    .reg2         (reg2),
    .reg3         (reg3),
    .spi_ovf      (spi_ovf),
    .addr_err     (addr_err)
`ifdef SPI_ARB_WRCOUNT_EN
    ,
    .wr_count     (wr_count)
`endif
  );

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge iclk);
    #1;
  endtask

  // reference model: a write that lands in a register
  task automatic mdl_wr(input logic [7:0] a, input logic [7:0] d);
    if (a == 8'd1) m1 = d;
    else if (a == 8'd2) m2 = d;
    else if (a == 8'd3) m3 = d;
    if (a >= 8'd1 && a <= 8'd3 && m_wc != 8'hFF) m_wc = m_wc + 8'd1;
  endtask

  task automatic chk_regs(input string tag);
    chk({tag, "_r1"}, reg1, m1);
    chk({tag, "_r2"}, reg2, m2);
    chk({tag, "_r3"}, reg3, m3);
`ifdef SPI_ARB_WRCOUNT_EN
    chk({tag, "_wc"}, wr_count, m_wc);
`endif
  endtask

  // strobe sampled on the next edge (edge k); returns just after it
  task automatic spi_wr(input logic [7:0] a, input logic [7:0] d);
    spi_addr = a;
    spi_wdata = d;
    spi_wr_valid = 1'b1;
    tick();
    spi_wr_valid = 1'b0;
  endtask

  task automatic wait_gnt(input string tag);
    seen = 1'b0;
    for (int i = 0; i < 16 && !seen; i++) begin
      tick();
      if (int_wr_gnt) seen = 1'b1;
    end
    int_wr_req = 1'b0;
    chk(tag, 8'(seen), 8'd1);
    tick();
  endtask

  task automatic int_write(input logic [7:0] a, input logic [7:0] d,
                           input logic e_err, input logic e_aerr);
    int_addr = a;
    int_wdata = d;
    int_wr_req = 1'b1;
    sb_q.push_back('{err: e_err, aerr: e_aerr});
    wait_gnt("int_gnt_wait");
  endtask

  // scoreboard: each grant consumes one expected outcome
  always @(negedge iclk) begin
    if (rstn && int_wr_gnt) begin
      if (sb_q.size() == 0) begin
        chk("gnt_unexp", 8'(int_wr_gnt), 8'd0);
      end else begin
        mon_e = sb_q.pop_front();
        chk("gnt_err", 8'(int_wr_err), 8'(mon_e.err));
        chk("gnt_aerr", 8'(addr_err), 8'(mon_e.aerr));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0;
    spi_wr_valid = 1'b0; spi_addr = '0; spi_wdata = '0;
    int_wr_req = 1'b0; int_addr = '0; int_wdata = '0;
    m1 = R1; m2 = R2; m3 = R3; m_wc = 8'd0;
    tick(); tick();
    chk_regs("rst");
    chk("rst_gnt", 8'(int_wr_gnt), 8'd0);
    chk("rst_err", 8'(int_wr_err), 8'd0);
    chk("rst_ovf", 8'(spi_ovf), 8'd0);
    chk("rst_aerr", 8'(addr_err), 8'd0);
    rstn = 1'b1;
    tick();

    // SPI write lands two edges after the strobe
    spi_wr(8'd2, 8'h5A);
    tick();
    chk("a_early", reg2, m2);
    tick();
    mdl_wr(8'd2, 8'h5A);
    chk_regs("a");
    chk("a_aerr", 8'(addr_err), 8'd0);

    // simultaneous SPI strobe and internal request: SPI first
    spi_addr = 8'd1; spi_wdata = 8'h44; spi_wr_valid = 1'b1;
    int_addr = 8'd1; int_wdata = 8'h33; int_wr_req = 1'b1;
    sb_q.push_back('{err: 1'b0, aerr: 1'b0});
    tick();
    spi_wr_valid = 1'b0;
    tick();
    chk("b_k1", reg1, m1);
    tick();
    mdl_wr(8'd1, 8'h44);
    chk("b_spi", reg1, m1);
    chk("b_gnt0", 8'(int_wr_gnt), 8'd0);
    tick();
    mdl_wr(8'd1, 8'h33);
    chk("b_int", reg1, m1);
    chk("b_gnt", 8'(int_wr_gnt), 8'd1);
    int_wr_req = 1'b0;
    tick();

    // lock blocks internal writes
    spi_wr(8'd3, 8'h80); tick(); tick();
    mdl_wr(8'd3, 8'h80);
    chk_regs("c_lock");
    int_write(8'd1, 8'h11, 1'b1, 1'b0);
    chk_regs("c_refused");
    spi_wr(8'd3, 8'h00); tick(); tick();
    mdl_wr(8'd3, 8'h00);

    // overflow: two strobes while an internal commit is in flight
    int_addr = 8'd2; int_wdata = 8'h77; int_wr_req = 1'b1;
    sb_q.push_back('{err: 1'b0, aerr: 1'b0});
    tick();
    spi_addr = 8'd1; spi_wdata = 8'hAA; spi_wr_valid = 1'b1;
    tick();
    chk("d_gnt", 8'(int_wr_gnt), 8'd1);
    mdl_wr(8'd2, 8'h77);
    int_wr_req = 1'b0;
    spi_addr = 8'd2; spi_wdata = 8'hBB;
    tick();
    spi_wr_valid = 1'b0;
    chk("d_ovf", 8'(spi_ovf), 8'd1);
    tick(); tick();
    mdl_wr(8'd1, 8'hAA);
    chk_regs("d_kept");
    chk("d_ovf_sticky", 8'(spi_ovf), 8'd1);
    spi_wr(8'd3, 8'hFF); tick(); tick();
    mdl_wr(8'd3, 8'hFF);
    chk("d_ovf_clr", 8'(spi_ovf), 8'd0);
    chk_regs("d_ff");
    spi_wr(8'd3, 8'h00); tick(); tick();
    mdl_wr(8'd3, 8'h00);

    // bad addresses from both sources
    int_write(8'd7, 8'h99, 1'b0, 1'b1);
    chk_regs("e_int7");
    spi_wr(8'd0, 8'h12); tick(); tick();
    chk("e_spi0_aerr", 8'(addr_err), 8'd1);
    chk_regs("e_spi0");
    tick();
    chk("e_aerr_pulse", 8'(addr_err), 8'd0);
    spi_wr(8'd4, 8'h34); tick(); tick();
    chk("e_spi4_aerr", 8'(addr_err), 8'd1);
    chk_regs("e_spi4");

`ifdef SPI_ARB_WRCOUNT_EN
    // counter saturation
    for (int i = 0; i < 256; i++) begin
      spi_wr(8'd1, 8'(i)); tick(); tick();
      mdl_wr(8'd1, 8'(i));
    end
    chk_regs("sat");
`endif

    // reset during INT_COMMIT aborts; request re-granted after release
    int_addr = 8'd1; int_wdata = 8'h5C; int_wr_req = 1'b1;
    sb_q.push_back('{err: 1'b0, aerr: 1'b0});
    tick();
    rstn = 1'b0;
    #1;
    m1 = R1; m2 = R2; m3 = R3; m_wc = 8'd0;
    chk_regs("f_rst");
    chk("f_rst_gnt", 8'(int_wr_gnt), 8'd0);
    tick();
    chk_regs("f_rst_hold");
    rstn = 1'b1;
    wait_gnt("f_gnt_wait");
    mdl_wr(8'd1, 8'h5C);
    chk_regs("f_after");

    chk("sb_empty", 8'(sb_q.size()), 8'd0);
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
